rr_arb_mux: RTL and testbench

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/mux_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/rr_arb_mux.sv | 76 +++++++
 tb/tb_rr_arb_mux.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin arbitrated mux.
//   MUX_N   : default payload width per channel
//   MUX_M   : default number of input channels
//   mode_e  : arbitration mode (fixed priority or round-robin)
//   state_e : output register occupancy
package mux_pkg;

    localparam int MUX_N = 64;
    localparam int MUX_M = 4;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant logic for rr_arb_mux.
//   req   : per-channel request vector
//   ptr   : round-robin search start index
//   mode  : MODE_FIXED searches from 0, MODE_RR searches from ptr
//   grant : one-hot grant, zero when no request
//   idx   : index of the granted channel (0 when no request)
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int M = MUX_M,
    localparam int S = $clog2(M)
) (
    input  logic [M-1:0] req,
    input  logic [S-1:0] ptr,
    input  mode_e        mode,
    output logic [M-1:0] grant,
    output logic [S-1:0] idx
);

    logic [S-1:0] start;
    logic [S-1:0] cand;
    logic         found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        start = (mode == MODE_RR) ? ptr : '0;
        // Circular scan from start; modulo keeps non-power-of-two M correct.
        for (int unsigned i = 0; i < int'(M); i++) begin
            cand = S'((int'(start) + int'(i)) % M);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// M-to-1 arbitrated mux with a one-entry registered output stage.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_mode         : 0 fixed priority (lowest index), 1 round-robin
//   i_valid/o_ready: per-channel handshake, o_ready one-hot or zero
//   i_data         : packed per-channel payloads [M-1:0][N-1:0]
//   o_valid/i_ready: output handshake
//   o_data, o_sel  : registered payload and its source channel index
module rr_arb_mux
    import mux_pkg::*;
#(
    parameter int N = MUX_N,
    parameter int M = MUX_M,
    localparam int S = $clog2(M)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_mode,
    input  logic [M-1:0]        i_valid,
    input  logic [M-1:0][N-1:0] i_data,
    output logic [M-1:0]        o_ready,
    output logic                o_valid,
    output logic [N-1:0]        o_data,
    output logic [S-1:0]        o_sel,
    input  logic                i_ready
);

    state_e       state;
    state_e       state_nx;
    logic [S-1:0] ptr;
    logic [M-1:0] grant;
    logic [S-1:0] gidx;
    logic         acc;
    logic         in_xfer;
    logic         out_xfer;

    rr_arbiter #(.M(M)) u_arb (
        .req   (i_valid),
        .ptr   (ptr),
        .mode  (mode_e'(i_mode)),
        .grant (grant),
        .idx   (gidx)
    );

    assign o_valid  = (state == ST_FULL);
    assign acc      = !o_valid || i_ready;
    // Reset gating keeps o_ready quiet while the register is held in reset.
    assign o_ready  = (acc && i_rst_n) ? grant : '0;
    assign in_xfer  = |o_ready;
    assign out_xfer = o_valid && i_ready;

    always_comb begin
        state_nx = state;
        case (state)
            ST_EMPTY: if (in_xfer) state_nx = ST_FULL;
            ST_FULL:  if (out_xfer && !in_xfer) state_nx = ST_EMPTY;
            default:  state_nx = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_EMPTY;
            ptr    <= '0;
            o_data <= '0;
            o_sel  <= '0;
        end else begin
            state <= state_nx;
            if (in_xfer) begin
                o_data <= i_data[gidx];
                o_sel  <= gidx;
                ptr    <= (gidx == S'(M - 1)) ? '0 : gidx + S'(1);
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

    localparam int N = 64;
    localparam int M = 4;
    localparam int S = 2;

    localparam logic [N-1:0] DA = {16{4'hA}};
    localparam logic [N-1:0] DB = {16{4'hB}};
    localparam logic [N-1:0] DC = {16{4'hC}};
    localparam logic [N-1:0] DD = {16{4'hD}};

    logic                i_clk = 1'b0;
    logic                i_rst_n;
    logic                i_mode;
    logic [M-1:0]        i_valid;
    logic [M-1:0][N-1:0] i_data;
    logic [M-1:0]        o_ready;
    logic                o_valid;
    logic [N-1:0]        o_data;
    logic [S-1:0]        o_sel;
    logic                i_ready;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] dtab [4];
    logic [M-1:0] rdy_exp;

    rr_arb_mux #(.N(N), .M(M)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_mode  (i_mode),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_sel   (o_sel),
        .i_ready (i_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        dtab[0] = DA; dtab[1] = DB; dtab[2] = DC; dtab[3] = DD;
        i_data  = {DD, DC, DB, DA};
        i_rst_n = 1'b0;
        i_mode  = 1'b1;
        i_valid = 4'b1111;
        i_ready = 1'b1;

        // Reset state, requests present but nothing granted
        tick();
        #1;
        chk("rst_o_valid", N'(o_valid), '0);
        chk("rst_o_data", o_data, '0);
        chk("rst_o_sel", N'(o_sel), '0);
        chk("rst_o_ready", N'(o_ready), '0);
        i_valid = '0;
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // First beat: channel 0, one cycle latency
        tick();
        i_valid = 4'b0001;
        #1;
        chk("first_o_ready", N'(o_ready), N'(4'b0001));
        tick();
        chk("first_o_valid", N'(o_valid), N'(1'b1));
        chk("first_o_data", o_data, DA);
        chk("first_o_sel", N'(o_sel), '0);
        i_valid = '0;
        tick();
        chk("drain_o_valid", N'(o_valid), '0);
        chk("empty_hold_data", o_data, DA);
        chk("empty_hold_sel", N'(o_sel), '0);

        // ptr=1: request on 3 only, then ptr wraps to 0
        i_valid = 4'b1000;
        #1;
        chk("ch3_o_ready", N'(o_ready), N'(4'b1000));
        tick();
        chk("ch3_o_sel", N'(o_sel), N'(2'd3));

        // Round-robin over all channels, one beat per cycle
        i_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            rdy_exp = 4'b0001 << (k % 4);
            chk($sformatf("rr_o_ready_%0d", k), N'(o_ready), N'(rdy_exp));
            tick();
            chk($sformatf("rr_o_sel_%0d", k), N'(o_sel), N'(k % 4));
            chk($sformatf("rr_o_data_%0d", k), o_data, dtab[k % 4]);
            chk($sformatf("rr_o_valid_%0d", k), N'(o_valid), N'(1'b1));
        end

        // Fixed priority with 1110: always channel 1
        i_mode  = 1'b0;
        i_valid = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("fix_o_ready_%0d", k), N'(o_ready), N'(4'b0010));
            tick();
            chk($sformatf("fix_o_sel_%0d", k), N'(o_sel), N'(2'd1));
        end
        // Switch to round-robin, ptr=2 kept
        i_mode = 1'b1;
        #1;
        chk("sw_o_ready", N'(o_ready), N'(4'b0100));
        tick();
        chk("sw_o_sel", N'(o_sel), N'(2'd2));
        chk("sw_o_data", o_data, DC);

        // Backpressure holding CCCC..., then release with 1001 at ptr=3
        i_ready = 1'b0;
        i_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_o_ready_%0d", k), N'(o_ready), '0);
            tick();
            chk($sformatf("bp_o_data_%0d", k), o_data, DC);
            chk($sformatf("bp_o_sel_%0d", k), N'(o_sel), N'(2'd2));
            chk($sformatf("bp_o_valid_%0d", k), N'(o_valid), N'(1'b1));
        end
        i_ready = 1'b1;
        #1;
        chk("rel_o_ready", N'(o_ready), N'(4'b1000));
        tick();
        chk("wrap_g3_sel", N'(o_sel), N'(2'd3));
        chk("wrap_g3_data", o_data, DD);
        chk("wrap_g3_valid", N'(o_valid), N'(1'b1));
        #1;
        chk("wrap_g0_o_ready", N'(o_ready), N'(4'b0001));
        tick();
        chk("wrap_g0_sel", N'(o_sel), '0);
        chk("wrap_g0_data", o_data, DA);

        // Hold FULL (ptr=1), then asynchronous reset mid-cycle
        i_valid = '0;
        i_ready = 1'b0;
        tick();
        chk("pre_rst_valid", N'(o_valid), N'(1'b1));
        #3;
        i_rst_n = 1'b0;
        i_valid = 4'b1001;
        #1;
        chk("arst_o_valid", N'(o_valid), '0);
        chk("arst_o_data", o_data, '0);
        chk("arst_o_sel", N'(o_sel), '0);
        chk("arst_o_ready", N'(o_ready), '0);
        #1;
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        // ptr=0 grants 0; a surviving ptr=1 would grant 3
        #1;
        chk("post_rst_o_ready", N'(o_ready), N'(4'b0001));
        tick();
        chk("post_rst_sel", N'(o_sel), '0);
        chk("post_rst_data", o_data, DA);
        chk("post_rst_valid", N'(o_valid), N'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
